dff_pipe_ar: RTL

- Parametrised elastic register pipeline; successor to the fixed 8-bit async-reset D flip-flop bank.
- Carries WIDTH-bit words through DEPTH register stages.
- Provides valid/ready backpressure, per-stage bubble collapsing, synchronous flush and an occupancy count.
- Used as a generic retiming/delay line between datapath blocks.

---
 rtl/dff_pipe_ar_pkg.sv | 9 +
 rtl/dff_pipe_stage.sv | 50 +++++
 rtl/dff_pipe_ar.sv | 103 ++++++++++
 3 files changed

// File: rtl/dff_pipe_ar_pkg.sv
// Shared helpers for the dff_pipe_ar elastic register pipeline.
package dff_pipe_ar_pkg;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: valid bit plus data word with async reset.
// Loads from upstream only when advancing; data holds on bubbles and on flush.
module dff_pipe_stage #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             flush,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state: flush clears valid, advance takes upstream word, else hold.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (adv) begin
            v_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Stage registers with asynchronous reset to the configured reset word.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            v_q    <= 1'b0;
            data_q <= RESET_VAL;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign out_valid = v_q;
    assign out_data  = data_q;

endmodule

// File: rtl/dff_pipe_ar.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit words with valid/ready
// backpressure, bubble collapsing, synchronous flush and occupancy count.
module dff_pipe_ar
    import dff_pipe_ar_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            areset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                d,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                q,
    input  logic                            flush,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned CW = count_width(DEPTH);

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] stg_v;
    logic [WIDTH-1:0] stg_data [DEPTH];
    logic [DEPTH-1:0] stg_in_v;
    logic [WIDTH-1:0] stg_in_d [DEPTH];

    logic             accept;
    logic             emit;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Advance chain, walked from the output end: a stage may move when it or
    // any stage downstream of it is empty, or the sink is taking the head word.
    // Accumulated in a running term so no bit of adv reads another.
    always_comb begin
        logic run;
        adv = '0;
        run = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            run                = run | ~stg_v[DEPTH-1-k];
            adv[DEPTH-1-k]     = run;
        end
    end

    assign in_ready  = adv[0] & ~flush & ~areset;
    assign out_valid = stg_v[DEPTH-1];
    assign q         = stg_data[DEPTH-1];
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stg_in_v[i] = in_valid;
            assign stg_in_d[i] = d;
        end else begin : g_body
            assign stg_in_v[i] = stg_v[i-1];
            assign stg_in_d[i] = stg_data[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .areset    (areset),
            .flush     (flush),
            .adv       (adv[i]),
            .in_valid  (stg_in_v[i]),
            .in_data   (stg_in_d[i]),
            .out_valid (stg_v[i]),
            .out_data  (stg_data[i])
        );
    end

    // Occupancy next state: +1 on accept, -1 on emit, cleared by flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({accept, emit})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
